mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 6 +
 rtl/mem_arb_prio.sv | 26 ++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, grant-owner types and defaults for the memory port arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT, RESP} state_e;
    typedef enum logic {GNT_IF, GNT_DM} gnt_e;
    localparam int MAX_D_STREAK_DEF = 4;
endpackage

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: data-first grant selection with a saturating streak counter that forces a fetch
module mem_arb_prio
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic grant_en_i,
    input  logic if_req_i,
    input  logic dm_req_i,
    output gnt_e gnt_o
);
    localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);
    logic [3:0] streak_q, streak_d;
    always_comb begin
        gnt_o    = (dm_req_i && !(if_req_i && streak_q == MAX_S)) ? GNT_DM : GNT_IF;
        streak_d = !(grant_en_i && (if_req_i || dm_req_i)) ? streak_q :
                   (gnt_o == GNT_IF || !if_req_i)          ? 4'd0 :
                   (streak_q == MAX_S)                     ? streak_q : streak_q + 4'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) streak_q <= 4'd0;
        else     streak_q <= streak_d;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and the load/store path
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_done,
    input  logic                  dm_req,
    input  logic [DATA_W/8-1:0]   dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  dm_done,
    output logic                  mem_cs,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);
    state_e                state_q, state_d;
    gnt_e                  gnt_q, gnt_d, gnt;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W/8-1:0]   we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     dm_rdata_q, dm_rdata_d;

    mem_arb_prio #(.MAX_D_STREAK(MAX_D_STREAK)) u_prio (
        .clk       (clk),
        .rst       (rst),
        .grant_en_i(state_q == IDLE),
        .if_req_i  (if_req),
        .dm_req_i  (dm_req),
        .gnt_o     (gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            IDLE: if (if_req || dm_req) begin
                state_d = ISSUE;
                gnt_d   = gnt;
                addr_d  = (gnt == GNT_DM) ? dm_addr : if_addr;
                we_d    = (gnt == GNT_DM) ? dm_we : '0;
                wdata_d = (gnt == GNT_DM) ? dm_wdata : '0;
            end
            ISSUE:   if (mem_ready) state_d = (|we_q) ? RESP : RD_WAIT;
            RD_WAIT: if (mem_rvalid) begin
                state_d = RESP;
                if (gnt_q == GNT_DM) dm_rdata_d = mem_rdata;
                else                 if_rdata_d = mem_rdata;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_IF;
            addr_q     <= '0;
            we_q       <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_cs    = state_q == ISSUE;
    assign mem_we    = mem_cs ? we_q : '0;
    assign mem_addr  = mem_cs ? addr_q : '0;
    assign mem_wdata = mem_cs ? wdata_q : '0;
    assign if_done   = state_q == RESP && gnt_q == GNT_IF;
    assign dm_done   = state_q == RESP && gnt_q == GNT_DM;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign stall_mem = dm_req && !dm_done;
    assign stall_if  = (if_req && !if_done) || stall_mem;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of load, store, contention, starvation guard and reset
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, dm_req = 1'b0;
    logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
    logic [3:0]  dm_we = '0;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic        if_done, dm_done, mem_cs, stall_if, stall_mem;
    logic [3:0]  mem_we;
    logic        mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    int          checks = 0, failures = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic serve(input string tag, input logic [31:0] exp_addr, input bit fetch);
        int n = 0;
        while (mem_cs !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_addr"}, mem_addr, exp_addr);
        step();
        if (fetch) begin
            mem_rvalid = 1'b1;
            mem_rdata  = 32'hC0DE0000;
            step();
            mem_rvalid = 1'b0;
        end
        chk({tag, "_done"}, {30'b0, if_done, dm_done}, fetch ? 32'd2 : 32'd1);
    endtask

    initial begin
        repeat (2) step();
        chk("rst_cs", {31'b0, mem_cs}, 0);
        chk("rst_done", {30'b0, if_done, dm_done}, 0);
        chk("rst_rdata", dm_rdata | if_rdata, 0);
        chk("rst_stall", {30'b0, stall_if, stall_mem}, 0);
        rst = 1'b0;
        step();

        // single load
        dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h100;
        #1;
        chk("ld_stall_idle", {31'b0, stall_mem}, 1);
        step();
        chk("ld_issue_cs", {31'b0, mem_cs}, 1);
        chk("ld_issue_addr", mem_addr, 32'h100);
        chk("ld_issue_we", {28'b0, mem_we}, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("ld_wait_cs", {31'b0, mem_cs}, 0);
        chk("ld_wait_stall", {31'b0, stall_mem}, 1);
        mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        step();
        mem_rvalid = 1'b0;
        chk("ld_done", {31'b0, dm_done}, 1);
        chk("ld_rdata", dm_rdata, 32'hDEADBEEF);
        chk("ld_done_stall", {31'b0, stall_mem}, 0);
        dm_req = 1'b0;
        step();
        chk("ld_done_pulse", {31'b0, dm_done}, 0);
        chk("ld_rdata_hold", dm_rdata, 32'hDEADBEEF);

        // store with three cycles of backpressure
        dm_req = 1'b1; dm_we = 4'b0011; dm_addr = 32'h204; dm_wdata = 32'h12345678;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("st_cs", {31'b0, mem_cs}, 1);
            chk("st_we", {28'b0, mem_we}, 32'h3);
            chk("st_addr", mem_addr, 32'h204);
            chk("st_wdata", mem_wdata, 32'h12345678);
            chk("st_done_early", {31'b0, dm_done}, 0);
            if (i == 3) mem_ready = 1'b1;
            step();
        end
        mem_ready = 1'b0;
        chk("st_done", {31'b0, dm_done}, 1);
        chk("st_rdata_keep", dm_rdata, 32'hDEADBEEF);
        dm_req = 1'b0;
        step();

        // contention: data first, then fetch, then back-to-back fetch
        if_req = 1'b1; if_addr = 32'h0; dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h80;
        step();
        chk("ct_first_addr", mem_addr, 32'h80);
        chk("ct_first_cs", {31'b0, mem_cs}, 1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5A5A5;
        step();
        mem_rvalid = 1'b0;
        chk("ct_dm_done", {30'b0, if_done, dm_done}, 1);
        chk("ct_dm_rdata", dm_rdata, 32'hA5A5A5A5);
        chk("ct_stall_if", {31'b0, stall_if}, 1);
        dm_req = 1'b0; dm_we = 4'hF;
        step();
        chk("ct_stall_if_idle", {31'b0, stall_if}, 1);
        step();
        chk("ct_if_cs", {31'b0, mem_cs}, 1);
        chk("ct_if_addr", mem_addr, 32'h0);
        chk("ct_if_we", {28'b0, mem_we}, 0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0BADF00D;
        step();
        mem_rvalid = 1'b0;
        chk("ct_if_done", {30'b0, if_done, dm_done}, 2);
        chk("ct_if_rdata", if_rdata, 32'h0BADF00D);
        chk("ct_stall_if_done", {31'b0, stall_if}, 0);
        if_addr = 32'h4;
        step();
        chk("b2b_idle_cs", {31'b0, mem_cs}, 0);
        chk("b2b_if_done_pulse", {31'b0, if_done}, 0);
        step();
        chk("b2b_cs", {31'b0, mem_cs}, 1);
        chk("b2b_addr", mem_addr, 32'h4);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h11112222;
        step();
        mem_rvalid = 1'b0;
        chk("b2b_done", {30'b0, if_done, dm_done}, 2);
        chk("b2b_rdata", if_rdata, 32'h11112222);
        if_req = 1'b0;
        step();

        // starvation guard: four data grants, one fetch, then data again
        if_req = 1'b1; if_addr = 32'h40;
        dm_req = 1'b1; dm_we = 4'hF; dm_addr = 32'h300; dm_wdata = 32'h55AA55AA;
        mem_ready = 1'b1;
        serve("sv_d1", 32'h300, 1'b0);
        serve("sv_d2", 32'h300, 1'b0);
        serve("sv_d3", 32'h300, 1'b0);
        serve("sv_d4", 32'h300, 1'b0);
        serve("sv_f", 32'h40, 1'b1);
        serve("sv_d5", 32'h300, 1'b0);
        if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
        step();

        // reset during RD_WAIT with read data still in flight
        dm_req = 1'b1; dm_we = 4'h0; dm_addr = 32'h500; mem_ready = 1'b1;
        step();
        step();
        mem_ready = 1'b0;
        chk("rr_in_wait", {31'b0, mem_cs}, 0);
        #2;
        rst = 1'b1; dm_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33334444;
        #1;
        chk("rr_cs", {31'b0, mem_cs}, 0);
        chk("rr_rdata", dm_rdata, 0);
        chk("rr_if_rdata", if_rdata, 0);
        chk("rr_stall", {30'b0, stall_if, stall_mem}, 0);
        step();
        chk("rr_done_in_rst", {30'b0, if_done, dm_done}, 0);
        rst = 1'b0;
        step();
        chk("rr_done_after", {30'b0, if_done, dm_done}, 0);
        chk("rr_rdata_after", dm_rdata, 0);
        chk("rr_cs_after", {31'b0, mem_cs}, 0);
        mem_rvalid = 1'b0;
        dm_req = 1'b1; dm_we = 4'hF; dm_addr = 32'h600; mem_ready = 1'b1;
        step();
        chk("rr_idle_cs", {31'b0, mem_cs}, 1);
        chk("rr_idle_addr", mem_addr, 32'h600);
        step();
        chk("rr_wr_done", {30'b0, if_done, dm_done}, 1);
        dm_req = 1'b0; mem_ready = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
